// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// with a req/ack memory handshake, one-cycle ready pulses and fetch cancellation on flush.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    logic [1:0] state_r;
    logic       last_data_r;
    logic       handoff_s;
    logic       fetch_pend_s;
    logic       grant_data_s;
    logic       grant_fetch_s;

    // Grant decision: no grant in a handoff cycle; on contention alternate using last_data_r.
    always_comb begin
        handoff_s     = if_ready | d_ready;
        fetch_pend_s  = if_req & ~if_flush;
        grant_data_s  = 1'b0;
        grant_fetch_s = 1'b0;
        if ((state_r == ST_IDLE) && !handoff_s) begin
            if (d_req && fetch_pend_s) begin
                grant_data_s  = ~last_data_r;
                grant_fetch_s = last_data_r;
            end else begin
                grant_data_s  = d_req;
                grant_fetch_s = fetch_pend_s;
            end
        end else begin
            grant_data_s  = 1'b0;
            grant_fetch_s = 1'b0;
        end
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

    // Grant FSM, latched memory command and registered return data / ready pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_data_r <= 1'b0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= {ADDR_W{1'b0}};
            m_wdata     <= {DATA_W{1'b0}};
            m_wstrb     <= {STRB_W{1'b0}};
            if_rdata    <= {DATA_W{1'b0}};
            d_rdata     <= {DATA_W{1'b0}};
            if_ready    <= 1'b0;
            d_ready     <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_data_s) begin
                        state_r <= ST_DATA;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_wstrb <= d_wstrb;
                    end else if (grant_fetch_s) begin
                        state_r <= ST_FETCH;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wstrb <= {STRB_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (m_ack) begin
                        state_r     <= ST_IDLE;
                        m_req       <= 1'b0;
                        last_data_r <= 1'b0;
                        // A flush coinciding with completion discards the fetched word.
                        if (!if_flush) begin
                            if_rdata <= m_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if_ready <= 1'b0;
                        end
                    end else if (if_flush) begin
                        state_r <= ST_DROP;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DATA: begin
                    if (m_ack) begin
                        state_r     <= ST_IDLE;
                        m_req       <= 1'b0;
                        last_data_r <= 1'b1;
                        d_rdata     <= m_rdata;
                        d_ready     <= 1'b1;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DROP: begin
                    if (m_ack) begin
                        state_r <= ST_IDLE;
                        m_req   <= 1'b0;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    m_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, fetch, contention,
// store timing and flush behaviour with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ack;

    int total;
    int bad;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        m_rdata = 32'h0; m_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        if (m_req !== 1'b0) begin bad++; $display("FAIL rst_m_req got=%h exp=0", m_req); end total++;
        if (m_we !== 1'b0) begin bad++; $display("FAIL rst_m_we got=%h exp=0", m_we); end total++;
        if (m_addr !== 32'h0) begin bad++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end total++;
        if (m_wstrb !== 4'h0) begin bad++; $display("FAIL rst_m_wstrb got=%h exp=0", m_wstrb); end total++;
        if (if_ready !== 1'b0 || d_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b%b exp=00", if_ready, d_ready); end total++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end total++;
        // Start a load, then reset while it is outstanding.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        @(negedge clk);
        if (m_req !== 1'b1 || m_addr !== 32'h3000) begin bad++; $display("FAIL rst_pre_grant got=%h/%h exp=1/3000", m_req, m_addr); end total++;
        #1 rst = 1'b1;
        #1;
        if (m_req !== 1'b0 || m_addr !== 32'h0) begin bad++; $display("FAIL rst_async got=%h/%h exp=0/0", m_req, m_addr); end total++;
        @(posedge clk);
        #1 rst = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (d_ready !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL rst_abandon got=%b/%b exp=0/0", d_ready, m_req); end total++;
        end
    endtask

    task automatic test_fetch_zero_wait();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        if (m_req !== 1'b1 || m_addr !== 32'h100) begin bad++; $display("FAIL fetch_grant got=%h/%h exp=1/100", m_req, m_addr); end total++;
        if (m_we !== 1'b0 || m_wstrb !== 4'h0) begin bad++; $display("FAIL fetch_we_strb got=%h/%h exp=0/0", m_we, m_wstrb); end total++;
        if (stall_if !== 1'b1) begin bad++; $display("FAIL fetch_stall got=%h exp=1", stall_if); end total++;
        m_ack = 1'b1; m_rdata = 32'h00500093;
        @(posedge clk);
        #1 m_ack = 1'b0; m_rdata = 32'h0;
        @(negedge clk);
        if (if_ready !== 1'b1 || if_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_ready got=%h/%h exp=1/00500093", if_ready, if_rdata); end total++;
        if (m_req !== 1'b0 || stall_if !== 1'b0) begin bad++; $display("FAIL fetch_done got=%h/%h exp=0/0", m_req, stall_if); end total++;
        @(negedge clk);
        if (if_ready !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL fetch_handoff got=%h/%h exp=0/0", if_ready, m_req); end total++;
        if_req = 1'b0;
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        @(negedge clk);
        if (m_req !== 1'b1 || m_addr !== 32'h2000 || m_we !== 1'b0) begin bad++; $display("FAIL cont_data_first got=%h/%h/%h exp=1/2000/0", m_req, m_addr, m_we); end total++;
        m_ack = 1'b1; m_rdata = 32'h11223344;
        @(posedge clk);
        #1 m_ack = 1'b0;
        @(negedge clk);
        if (d_ready !== 1'b1 || d_rdata !== 32'h11223344 || if_ready !== 1'b0) begin bad++; $display("FAIL cont_d_ready got=%h/%h/%h exp=1/11223344/0", d_ready, d_rdata, if_ready); end total++;
        d_addr = 32'h2008;
        @(negedge clk);
        if (m_req !== 1'b0) begin bad++; $display("FAIL cont_handoff got=%h exp=0", m_req); end total++;
        @(negedge clk);
        if (m_req !== 1'b1 || m_addr !== 32'h104 || m_we !== 1'b0) begin bad++; $display("FAIL cont_fetch_next got=%h/%h/%h exp=1/104/0", m_req, m_addr, m_we); end total++;
        m_ack = 1'b1; m_rdata = 32'hAAAA5555;
        @(posedge clk);
        #1 m_ack = 1'b0;
        @(negedge clk);
        if (if_ready !== 1'b1 || if_rdata !== 32'hAAAA5555 || d_ready !== 1'b0) begin bad++; $display("FAIL cont_if_ready got=%h/%h/%h exp=1/aaaa5555/0", if_ready, if_rdata, d_ready); end total++;
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        @(negedge clk);
        if (m_req !== 1'b0) begin bad++; $display("FAIL store_handoff got=%h exp=0", m_req); end total++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h2004) begin bad++; $display("FAIL store_cmd%0d got=%h/%h/%h exp=1/1/2004", k, m_req, m_we, m_addr); end total++;
            if (m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'b0011) begin bad++; $display("FAIL store_data%0d got=%h/%h exp=deadbeef/3", k, m_wdata, m_wstrb); end total++;
            if (stall_mem !== 1'b1 || d_ready !== 1'b0) begin bad++; $display("FAIL store_stall%0d got=%h/%h exp=1/0", k, stall_mem, d_ready); end total++;
        end
        m_ack = 1'b1; m_rdata = 32'h55AA55AA;
        @(posedge clk);
        #1 m_ack = 1'b0;
        @(negedge clk);
        if (d_ready !== 1'b1 || stall_mem !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL store_done got=%h/%h/%h exp=1/0/0", d_ready, stall_mem, m_req); end total++;
        if (d_rdata !== 32'h55AA55AA) begin bad++; $display("FAIL store_rdata got=%h exp=55aa55aa", d_rdata); end total++;
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        if (m_req !== 1'b1 || m_addr !== 32'h200) begin bad++; $display("FAIL flush_grant got=%h/%h exp=1/200", m_req, m_addr); end total++;
        if_flush = 1'b1;
        @(posedge clk);
        #1 if_flush = 1'b0; if_addr = 32'h300;
        @(negedge clk);
        if (m_req !== 1'b1 || if_ready !== 1'b0) begin bad++; $display("FAIL flush_drop got=%h/%h exp=1/0", m_req, if_ready); end total++;
        @(negedge clk);
        if (m_req !== 1'b1 || m_addr !== 32'h200) begin bad++; $display("FAIL flush_drop_hold got=%h/%h exp=1/200", m_req, m_addr); end total++;
        m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1 m_ack = 1'b0;
        @(negedge clk);
        if (if_ready !== 1'b0 || m_req !== 1'b0 || if_rdata !== 32'hAAAA5555) begin bad++; $display("FAIL flush_drop_done got=%h/%h/%h exp=0/0/aaaa5555", if_ready, m_req, if_rdata); end total++;
        @(negedge clk);
        if (m_req !== 1'b1 || m_addr !== 32'h300) begin bad++; $display("FAIL flush_regrant got=%h/%h exp=1/300", m_req, m_addr); end total++;
        m_ack = 1'b1; if_flush = 1'b1; m_rdata = 32'hBAD1BAD1;
        @(posedge clk);
        #1 m_ack = 1'b0; if_flush = 1'b0; if_req = 1'b0;
        @(negedge clk);
        if (if_ready !== 1'b0 || m_req !== 1'b0 || if_rdata !== 32'hAAAA5555) begin bad++; $display("FAIL flush_ack_cycle got=%h/%h/%h exp=0/0/aaaa5555", if_ready, m_req, if_rdata); end total++;
    endtask

    task automatic test_flush_data();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2010;
        @(negedge clk);
        if (m_req !== 1'b1 || m_addr !== 32'h2010) begin bad++; $display("FAIL fdata_grant got=%h/%h exp=1/2010", m_req, m_addr); end total++;
        if_flush = 1'b1;
        @(posedge clk);
        #1 if_flush = 1'b0;
        @(negedge clk);
        if (m_req !== 1'b1 || m_we !== 1'b0) begin bad++; $display("FAIL fdata_hold got=%h/%h exp=1/0", m_req, m_we); end total++;
        m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 m_ack = 1'b0;
        @(negedge clk);
        if (d_ready !== 1'b1 || d_rdata !== 32'hCAFEF00D || if_ready !== 1'b0) begin bad++; $display("FAIL fdata_ready got=%h/%h/%h exp=1/cafef00d/0", d_ready, d_rdata, if_ready); end total++;
        d_req = 1'b0;
        @(negedge clk);
        if (d_ready !== 1'b0) begin bad++; $display("FAIL fdata_pulse_len got=%h exp=0", d_ready); end total++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fetch_zero_wait();
        test_contention();
        test_store();
        test_flush();
        test_flush_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
